ro_sts_reg_bank: RTL and testbench



---
 rtl/ro_reg_pkg.sv | 25 ++
 rtl/ro_sts_reg_bank_if.sv | 24 ++
 rtl/ro_sts_reg_slice.sv | 59 +++++
 rtl/ro_sts_reg_bank.sv | 87 ++++++++
 tb/tb_ro_sts_reg_bank.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ro_reg_pkg.sv
// Shared helpers for the read-only status register bank: address-window decode
// and per-register sticky-mask extraction.
package ro_reg_pkg;

    localparam int unsigned MAX_AW     = 32;
    localparam int unsigned MAX_DW     = 64;
    localparam int unsigned MAX_MASK_W = 4096;

    // One bit wider than the widest address so base + n never wraps.
    typedef logic [MAX_AW:0] addr_ext_t;

    function automatic logic in_range(input addr_ext_t addr, input addr_ext_t base,
                                      input addr_ext_t n);
        return (addr >= base) && (addr <= base + n - addr_ext_t'(1));
    endfunction

    function automatic logic [MAX_DW-1:0] sticky_mask_slice(input logic [MAX_MASK_W-1:0] mask,
                                                            input int unsigned k,
                                                            input int unsigned dw);
        logic [MAX_DW-1:0] keep;
        keep = (dw >= MAX_DW) ? {MAX_DW{1'b1}} : ~({MAX_DW{1'b1}} << dw);
        return MAX_DW'(mask >> (k * dw)) & keep;
    endfunction

endpackage

// File: rtl/ro_sts_reg_bank_if.sv
// Register-bus read port of the status bank: request, mode qualifiers and
// registered response.
interface ro_sts_reg_bank_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          i_ren;
    logic          i_test_mode_status;
    logic          i_cfg_mode_status;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] o_rdata;
    logic          o_rvld;
    logic          o_hit;

    modport slave (
        input  i_ren, i_test_mode_status, i_cfg_mode_status, i_addr,
        output o_rdata, o_rvld, o_hit
    );

    modport master (
        output i_ren, i_test_mode_status, i_cfg_mode_status, i_addr,
        input  o_rdata, o_rvld, o_hit
    );
endinterface

// File: rtl/ro_sts_reg_slice.sv
// One status register: sticky accumulation with optional clear-on-read, and an
// optional shadow copy used for coherent multi-register snapshots.
module ro_sts_reg_slice #(
    parameter int          DW     = 8,
    parameter logic [DW-1:0] STICKY = '0,
    parameter logic        RC     = 1'b0,
    parameter logic        SNAP   = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_ff_data,
    input  logic          i_rd,
    input  logic          i_snap,
    output logic [DW-1:0] o_eff,
    output logic [DW-1:0] o_shadow
);

    logic [DW-1:0] sticky_q;
    logic [DW-1:0] sticky_d;

    // Live data is OR-ed in so an event in the clearing read cycle is still reported.
    assign o_eff = sticky_q | i_ff_data;

    always_comb begin
        sticky_d = sticky_q | (i_ff_data & STICKY);
        if (RC && i_rd) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    generate
        if (SNAP) begin : g_snap
            logic [DW-1:0] shadow_q;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    shadow_q <= '0;
                end else if (i_snap) begin
                    shadow_q <= o_eff;
                end
            end

            assign o_shadow = shadow_q;
        end else begin : g_no_snap
            logic snap_unused;
            assign snap_unused = i_snap;
            assign o_shadow    = '0;
        end
    endgenerate

endmodule

// File: rtl/ro_sts_reg_bank.sv
// Bank of NREG read-only status registers: mode-gated address decode, read mux
// (live or snapshot) and registered read data with a one-cycle valid strobe.
module ro_sts_reg_bank
    import ro_reg_pkg::*;
#(
    parameter int                 DW                   = 8,
    parameter int                 AW                   = 8,
    parameter int                 NREG                 = 4,
    parameter logic [AW-1:0]      BASE_ADDR            = {AW{1'b0}},
    parameter logic [NREG*DW-1:0] STICKY_MASK          = {NREG*DW{1'b0}},
    parameter logic [NREG-1:0]    RC_MASK              = {NREG{1'b0}},
    parameter logic               SNAP_EN              = 1'b0,
    parameter logic               SUPPORT_TEST_MODE_RD = 1'b1,
    parameter logic               SUPPORT_CFG_MODE_RD  = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREG*DW-1:0] i_ff_data,
    ro_sts_reg_bank_if.slave   bus
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic             ren;
    logic             hit;
    logic             acc;
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    eff    [NREG];
    logic [DW-1:0]    shadow [NREG];
    logic [DW-1:0]    sel;
    logic [DW-1:0]    rdata_d;
    logic [DW-1:0]    rdata_q;
    logic             rvld_d;
    logic             rvld_q;

    assign ren = bus.i_ren & ((bus.i_test_mode_status & SUPPORT_TEST_MODE_RD) |
                              (bus.i_cfg_mode_status  & SUPPORT_CFG_MODE_RD));
    assign hit = in_range(addr_ext_t'(bus.i_addr), addr_ext_t'(BASE_ADDR), addr_ext_t'(NREG));
    assign acc = ren & hit;
    assign idx = IDX_W'(bus.i_addr - BASE_ADDR);

    assign bus.o_hit = acc;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            ro_sts_reg_slice #(
                .DW     (DW),
                .STICKY (DW'(sticky_mask_slice(MAX_MASK_W'(STICKY_MASK), gi, DW))),
                .RC     (RC_MASK[gi]),
                .SNAP   (SNAP_EN)
            ) u_slice (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_ff_data (i_ff_data[gi*DW +: DW]),
                .i_rd      (acc && (idx == IDX_W'(gi))),
                .i_snap    (acc && (idx == '0)),
                .o_eff     (eff[gi]),
                .o_shadow  (shadow[gi])
            );
        end
    endgenerate

    // Register 0 is always live; with snapshots the others come from the shadow copy.
    always_comb begin
        sel = eff[idx];
        if (SNAP_EN && (idx != '0)) begin
            sel = shadow[idx];
        end
        rdata_d = acc ? sel : '0;
        rvld_d  = acc;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
            rvld_q  <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
        end
    end

    assign bus.o_rdata = rdata_q;
    assign bus.o_rvld  = rvld_q;

endmodule

// File: tb/tb_ro_sts_reg_bank.sv
// Directed scoreboard bench: bank A (live reads, test-mode reads barred) and
// bank B (snapshot enabled) share clock and reset.
module tb_ro_sts_reg_bank;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int NREG = 4;
    localparam logic [NREG*DW-1:0] STK = 32'h0000_0F00;
    localparam logic [NREG-1:0]    RCM = 4'b0010;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        string      tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] ff_a;
    logic [31:0] ff_b;
    logic        hit_exp_a;
    logic        hit_exp_b;
    exp_t        q_a[$];
    exp_t        q_b[$];
    int          n_cmp;
    int          n_err;
    logic [7:0]  exp5_a [4];
    logic [7:0]  exp5_b [4];

    ro_sts_reg_bank_if #(.AW(AW), .DW(DW)) bus_a ();
    ro_sts_reg_bank_if #(.AW(AW), .DW(DW)) bus_b ();

    ro_sts_reg_bank #(
        .DW(DW), .AW(AW), .NREG(NREG), .BASE_ADDR(8'h10), .STICKY_MASK(STK), .RC_MASK(RCM),
        .SNAP_EN(1'b0), .SUPPORT_TEST_MODE_RD(1'b0), .SUPPORT_CFG_MODE_RD(1'b1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ff_data(ff_a), .bus(bus_a)
    );

    ro_sts_reg_bank #(
        .DW(DW), .AW(AW), .NREG(NREG), .BASE_ADDR(8'h10), .STICKY_MASK(STK), .RC_MASK(RCM),
        .SNAP_EN(1'b1), .SUPPORT_TEST_MODE_RD(1'b0), .SUPPORT_CFG_MODE_RD(1'b1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ff_data(ff_b), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input logic [7:0] obs, input logic [7:0] expv, input string tag);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue a read on bank A (b=0) or B (b=1) and queue its expected response.
    task automatic drv(input bit b, input logic [7:0] addr, input logic tm, input logic cm,
                       input logic hit, input logic ev, input logic [7:0] ed, input string tag);
        exp_t e;
        e.vld  = ev;
        e.data = ed;
        e.tag  = tag;
        if (!b) begin
            bus_a.i_ren = 1'b1; bus_a.i_addr = addr;
            bus_a.i_test_mode_status = tm; bus_a.i_cfg_mode_status = cm;
            hit_exp_a = hit;
            q_a.push_back(e);
        end else begin
            bus_b.i_ren = 1'b1; bus_b.i_addr = addr;
            bus_b.i_test_mode_status = tm; bus_b.i_cfg_mode_status = cm;
            hit_exp_b = hit;
            q_b.push_back(e);
        end
    endtask

    // One clock: check o_hit mid-cycle, then the registered response after the edge.
    task automatic tick();
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        check(8'(bus_a.o_hit), 8'(hit_exp_a), "a_hit");
        check(8'(bus_b.o_hit), 8'(hit_exp_b), "b_hit");
        @(posedge clk);
        #1;
        if (q_a.size() > 0) ea = q_a.pop_front();
        else begin ea.vld = 1'b0; ea.data = 8'h00; ea.tag = "idle"; end
        if (q_b.size() > 0) eb = q_b.pop_front();
        else begin eb.vld = 1'b0; eb.data = 8'h00; eb.tag = "idle"; end
        check(8'(bus_a.o_rvld), 8'(ea.vld), {"a_vld_", ea.tag});
        check(bus_a.o_rdata, ea.data, {"a_data_", ea.tag});
        check(8'(bus_b.o_rvld), 8'(eb.vld), {"b_vld_", eb.tag});
        check(bus_b.o_rdata, eb.data, {"b_data_", eb.tag});
        if (ea.tag != "idle")
            $display("[%0t] A %-22s rvld=%0b rdata=%h", $time, ea.tag, bus_a.o_rvld, bus_a.o_rdata);
        if (eb.tag != "idle")
            $display("[%0t] B %-22s rvld=%0b rdata=%h", $time, eb.tag, bus_b.o_rvld, bus_b.o_rdata);
        bus_a.i_ren = 1'b0; hit_exp_a = 1'b0;
        bus_b.i_ren = 1'b0; hit_exp_b = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        ff_a  = {8'hD4, 8'hC3, 8'h00, 8'hA1};
        ff_b  = {8'h3C, 8'hAA, 8'h00, 8'h7B};
        hit_exp_a = 1'b0; hit_exp_b = 1'b0;
        bus_a.i_ren = 1'b0; bus_a.i_addr = 8'h00;
        bus_a.i_test_mode_status = 1'b0; bus_a.i_cfg_mode_status = 1'b0;
        bus_b.i_ren = 1'b0; bus_b.i_addr = 8'h00;
        bus_b.i_test_mode_status = 1'b0; bus_b.i_cfg_mode_status = 1'b0;
        exp5_a = '{8'hA1, 8'h00, 8'hC3, 8'hD4};
        exp5_b = '{8'h7B, 8'h00, 8'h55, 8'hC5};

        // Reset and idle
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic read; bank B register 3 comes from the cleared shadow
        drv(0, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 8'hD4, "t1_rd13");
        drv(1, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "t1_shadow_rst");
        tick(); tick();

        // Mode gating and address window
        drv(0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "t2_tm_gated");  tick();
        drv(0, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, "t2_both_modes"); tick();
        drv(0, 8'h14, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "t2_oor_hi");    tick();
        drv(0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "t2_oor_lo");    tick();
        drv(0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "t2_no_mode");   tick();

        // Sticky capture and clear-on-read on register 1
        ff_a[10] = 1'b1; tick();
        ff_a[10] = 1'b0; tick(); tick();
        drv(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04, "t3_sticky");  tick();
        drv(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "t3_cleared"); tick();
        ff_a[8] = 1'b1;
        drv(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, "t3_coincident"); tick();
        ff_a[8] = 1'b0;
        drv(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "t3_after_coinc"); tick();
        ff_a[15:8] = 8'h30;
        drv(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h30, "t3_live");      tick();
        ff_a[15:8] = 8'h00;
        drv(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "t3_live_gone"); tick();

        // Snapshot coherence on bank B
        drv(1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7B, "t4_snap0"); tick();
        ff_b[23:16] = 8'h55;
        ff_b[31:24] = 8'hC5;
        drv(1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, "t4_shadow_old"); tick();
        drv(1, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, "t4_shadow3");    tick();
        drv(1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7B, "t4_snap1");      tick();
        drv(1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, "t4_shadow_new"); tick();

        // Clear-on-read through the shadow clears live sticky, not the shadow
        ff_b[10] = 1'b1; tick();
        ff_b[10] = 1'b0;
        drv(1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7B, "t4b_snap");        tick();
        drv(1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04, "t4b_shadow_stk");  tick();
        drv(1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04, "t4b_shadow_kept"); tick();
        drv(1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7B, "t4b_resnap");      tick();
        drv(1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "t4b_live_clr");    tick();

        // Back-to-back reads on both banks
        for (int i = 0; i < 4; i++) begin
            drv(0, 8'(16 + i), 1'b0, 1'b1, 1'b1, 1'b1, exp5_a[i], $sformatf("t5_b2b_%0d", i));
            drv(1, 8'(16 + i), 1'b0, 1'b1, 1'b1, 1'b1, exp5_b[i], $sformatf("t5_b2b_%0d", i));
            tick();
        end
        tick();

        // Reset mid-stream, coincident with a read, right after a sticky event
        ff_a[11] = 1'b1; tick();
        ff_a[11] = 1'b0;
        rst_n = 1'b0;
        drv(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "t6_rd_in_rst");
        drv(1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "t6_rd_in_rst");
        tick();
        rst_n = 1'b1;
        drv(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "t6_sticky_gone");
        drv(1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "t6_shadow_gone");
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
